// File: rtl/cdb_arbiter.sv
// cdb_arbiter: buffers per-FU results (add, mul, div, br) in private FIFOs and round-robins their heads onto one CDB.
// Ports: clk, rst (async, active-high); cdb_{add,mul,div,br}_in per-FU results, enqueued when .valid=1;
//   global_branch_signal flushes every FIFO and blanks cdb_out; cdb_out arbitrated broadcast ('0 when idle);
//   stall_{add,mul,div,br} occupancy >= FIFO_DEPTH-STALL_MARGIN; overflow sticky flag for a dropped result.
// Optional: define CDB_BR_PRIORITY_EN to let a non-empty br FIFO always win without advancing the rotation.
package cdb_pkg;
  typedef struct packed {
    logic        valid;
    logic [4:0]  rob_idx;
    logic [5:0]  pd_s;
    logic [31:0] rd_v;
    logic        pc_select;
    logic [31:0] pc_branch;
  } cdb_t;
endpackage

module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int STALL_MARGIN = 1
) (
  input  logic clk,
  input  logic rst,
  input  cdb_t cdb_add_in,
  input  cdb_t cdb_mul_in,
  input  cdb_t cdb_div_in,
  input  cdb_t cdb_br_in,
  input  logic global_branch_signal,
  output cdb_t cdb_out,
  output logic stall_add,
  output logic stall_mul,
  output logic stall_div,
  output logic stall_br,
  output logic overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] THR  = CW'(FIFO_DEPTH - STALL_MARGIN);
  cdb_t       in_v [4];
  cdb_t       head [4];
  logic [3:0] ne, deq, drop, stall;
  logic [1:0] rr, win;
  logic       gnt;
  assign in_v[0] = cdb_add_in;
  assign in_v[1] = cdb_mul_in;
  assign in_v[2] = cdb_div_in;
  assign in_v[3] = cdb_br_in;
  // Scan from rr+3 down to rr so the nearest non-empty source at or after rr is left in win.
  always_comb begin
    win = rr;
    for (int k = 3; k >= 0; k--)
      if (ne[rr + 2'(k)]) win = rr + 2'(k);
`ifdef CDB_BR_PRIORITY_EN
    if (ne[3]) win = 2'd3;
`endif
    gnt = |ne && !global_branch_signal;
  end
  assign cdb_out = gnt ? head[win] : '0;
  for (genvar i = 0; i < 4; i++) begin : g_src
    cdb_t          mem [FIFO_DEPTH];
    cdb_t          wd;
    logic [AW-1:0] wp, rp;
    logic [CW-1:0] cnt;
    logic          enq;
    assign ne[i]    = cnt != '0;
    assign deq[i]   = gnt && win == 2'(i);
    // A full FIFO still accepts when its head leaves on the same edge.
    assign enq      = in_v[i].valid && !global_branch_signal && (cnt != FULL || deq[i]);
    assign drop[i]  = in_v[i].valid && !global_branch_signal && cnt == FULL && !deq[i];
    assign stall[i] = cnt >= THR;
    assign head[i]  = mem[rp];
    always_comb begin
      wd = in_v[i];
      wd.valid = 1'b1;
    end
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        wp  <= '0;
        rp  <= '0;
        cnt <= '0;
      end else if (global_branch_signal) begin
        wp  <= '0;
        rp  <= '0;
        cnt <= '0;
      end else begin
        wp  <= enq ? wp + 1'b1 : wp;
        rp  <= deq[i] ? rp + 1'b1 : rp;
        cnt <= cnt + CW'(enq) - CW'(deq[i]);
      end
    always_ff @(posedge clk)
      if (enq) mem[wp] <= wd;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rr       <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= overflow | (|drop);
`ifdef CDB_BR_PRIORITY_EN
      if (gnt && win != 2'd3) rr <= win + 2'd1;
`else
      if (gnt) rr <= win + 2'd1;
`endif
    end
  assign stall_add = stall[0];
  assign stall_mul = stall[1];
  assign stall_div = stall[2];
  assign stall_br  = stall[3];
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed scoreboard bench for cdb_arbiter (FIFO_DEPTH=4, STALL_MARGIN=1).
module tb_cdb_arbiter;
  import cdb_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  cdb_t add_i, mul_i, div_i, br_i, out;
  logic s_add, s_mul, s_div, s_br, ovf;
  cdb_t sb[$];
  int n_assert = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cdb_arbiter #(.FIFO_DEPTH(4), .STALL_MARGIN(1)) dut (
    .clk(clk), .rst(rst),
    .cdb_add_in(add_i), .cdb_mul_in(mul_i), .cdb_div_in(div_i), .cdb_br_in(br_i),
    .global_branch_signal(flush), .cdb_out(out),
    .stall_add(s_add), .stall_mul(s_mul), .stall_div(s_div), .stall_br(s_br),
    .overflow(ovf)
  );

  function automatic cdb_t mk(int s, int j);
    cdb_t c;
    c = '0;
    c.valid = 1'b1;
    c.rob_idx = 5'(s * 8 + j);
    c.pd_s = 6'(s * 16 + j);
    c.rd_v = 32'(s * 65536 + j);
    c.pc_select = (s == 3);
    c.pc_branch = (s == 3) ? 32'(32'h8000 + j) : 32'h0;
    return c;
  endfunction

  task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic chk_c(string tag, cdb_t o, cdb_t e);
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    add_i = '0;
    mul_i = '0;
    div_i = '0;
    br_i  = '0;
  endtask

  task automatic do_reset();
    clear_in();
    flush = 1'b0;
    rst = 1'b1;
    sb.delete();
    #2;
    rst = 1'b0;
  endtask

  task automatic chk_idle(string tag, logic [4:0] flags);
    chk_c({tag, "_out"}, out, '0);
    chk({tag, "_flags"}, 32'({s_add, s_mul, s_div, s_br, ovf}), 32'(flags));
  endtask

  // Scoreboard: every broadcast must be the oldest outstanding expected result.
  always @(negedge clk)
    if (!rst && out.valid === 1'b1) begin
      if (sb.size() == 0) chk_c("unexpected_bcast", out, '0);
      else chk_c("bcast", out, sb.pop_front());
    end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    cdb_t e;
    clear_in();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk_idle("reset_idle", 5'b0);
      cyc();
    end
    // single add result: not visible in the cycle it is driven, visible exactly one cycle later
    e = '0;
    e.valid = 1'b1;
    e.rob_idx = 5'd5;
    e.pd_s = 6'd12;
    e.rd_v = 32'h1234;
    add_i = e;
    sb.push_back(e);
    @(negedge clk);
    chk("no_bypass", 32'(out.valid), 32'd0);
    cyc();
    clear_in();
    @(negedge clk);
    chk("add_valid", 32'(out.valid), 32'd1);
    cyc();
    @(negedge clk);
    chk("add_once", 32'(out.valid), 32'd0);
    cyc();
    chk("sb_single", 32'(sb.size()), 32'd0);
    // all four sources at once from rr_ptr=0
    do_reset();
    add_i = mk(0, 0);
    mul_i = mk(1, 0);
    div_i = mk(2, 0);
    br_i  = mk(3, 0);
`ifdef CDB_BR_PRIORITY_EN
    sb.push_back(mk(3, 0));
`endif
    sb.push_back(mk(0, 0));
    sb.push_back(mk(1, 0));
    sb.push_back(mk(2, 0));
`ifndef CDB_BR_PRIORITY_EN
    sb.push_back(mk(3, 0));
`endif
    cyc();
    clear_in();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("four_valid", 32'(out.valid), 32'd1);
      cyc();
    end
    @(negedge clk);
    chk("four_done", 32'(out.valid), 32'd0);
    cyc();
    chk("sb_four", 32'(sb.size()), 32'd0);
    // nine back-to-back mul results: one in, one out per cycle, occupancy stays at 1
    do_reset();
    for (int j = 0; j < 9; j++) begin
      mul_i = mk(1, j);
      sb.push_back(mk(1, j));
      @(negedge clk);
      chk("mul_stream_stall", 32'(s_mul), 32'd0);
      chk("mul_stream_ovf", 32'(ovf), 32'd0);
      cyc();
    end
    clear_in();
    repeat (3) cyc();
    chk("sb_mul", 32'(sb.size()), 32'd0);
    chk("mul_ovf_end", 32'(ovf), 32'd0);
    // fill div to 4 while add/mul also compete, then drop a div result
    do_reset();
    for (int j = 0; j < 5; j++) begin
      add_i = mk(0, j);
      mul_i = mk(1, j);
      div_i = mk(2, j);
      sb.push_back(mk(0, j));
      sb.push_back(mk(1, j));
      sb.push_back(mk(2, j));
      @(negedge clk);
      if (j == 4) chk("stall_at3", 32'({s_add, s_mul, s_div, s_br}), 32'b1110);
      cyc();
    end
    clear_in();
    div_i = mk(2, 5);
    @(negedge clk);
    chk("div_full_stall", 32'(s_div), 32'd1);
    chk("ovf_before_drop", 32'(ovf), 32'd0);
    cyc();
    clear_in();
    @(negedge clk);
    chk("ovf_after_drop", 32'(ovf), 32'd1);
    repeat (12) cyc();
    chk("ovf_sticky", 32'(ovf), 32'd1);
    chk("sb_ovf", 32'(sb.size()), 32'd0);
    // flush with three entries buffered and a br result in the same cycle
    do_reset();
    add_i = mk(0, 0);
    mul_i = mk(1, 0);
    div_i = mk(2, 0);
    cyc();
    clear_in();
    flush = 1'b1;
    br_i = mk(3, 9);
    @(negedge clk);
    chk_c("flush_out", out, '0);
    cyc();
    flush = 1'b0;
    clear_in();
    @(negedge clk);
    chk_idle("post_flush", 5'b0);
    repeat (3) cyc();
    add_i = mk(0, 7);
    sb.push_back(mk(0, 7));
    cyc();
    clear_in();
    repeat (2) cyc();
    chk("sb_flush", 32'(sb.size()), 32'd0);
    // asynchronous reset while the add head is on the bus
    do_reset();
    mul_i = mk(1, 0);
    sb.push_back(mk(1, 0));
    cyc();
    clear_in();
    add_i = mk(0, 0);
    div_i = mk(2, 0);
    sb.push_back(mk(2, 0));
    cyc();
    clear_in();
    add_i = mk(0, 1);
    cyc();
    clear_in();
    chk_c("pre_rst_head", out, mk(0, 0));
    #1 rst = 1'b1;
    sb.delete();
    #1;
    chk_c("async_rst_out", out, '0);
    chk("async_rst_flags", 32'({s_add, s_mul, s_div, s_br, ovf}), 32'd0);
    #1 rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk_idle("post_rst", 5'b0);
      cyc();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
